ec_rdc_conv: RTL and testbench
==============================

// Module: ec_rdc_conv
// PURPOSE
//  Downstream of the EC core. Converts redundant point results (xp,xn),(yp,yn) from ecp3_* to canonical binary mod P.
//  Computes x = (xp - xn) mod P and y = (yp - yn) mod P in two parallel lanes.
//  Uses a limb-serial subtract pass, then a conditional add-P pass.
//  Output feeds the host/SPI readback register file.
// PARAMETERS
//  WIDTH  256         operand width, bits
//  LIMB   64          datapath limb width; WIDTH % LIMB == 0; NL = WIDTH/LIMB (default 4)
//  P      256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF  modulus (P-256)
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous reset, active-high
//  conv_start in   1      capture operands, begin conversion; ignored unless idle
//  conv_clr   in   1      synchronous abort to IDLE; results retained
//  ecp3_xp    in   WIDTH  x positive part, 0 <= xp < P
//  ecp3_xn    in   WIDTH  x negative part, 0 <= xn < P
//  ecp3_yp    in   WIDTH  y positive part, 0 <= yp < P
//  ecp3_yn    in   WIDTH  y negative part, 0 <= yn < P
//  conv_busy  out  1      high from cycle after accepted start through DONE
//  conv_done  out  1      one-cycle pulse, x_out/y_out valid
//  x_out      out  WIDTH  canonical x, 0 <= x_out < P
//  y_out      out  WIDTH  canonical y, 0 <= y_out < P
// BEHAVIOUR
//  Clock and reset
//  - One clock. Reset is synchronous and active-high, ports clk and rst.
//  - On rst: state IDLE; conv_busy=0, conv_done=0, x_out=0, y_out=0.
//  - All operand/limb registers and borrow/carry bits are cleared on rst.
//  States: IDLE -> SUB -> CHK -> (ADD) -> DONE -> IDLE
//  - IDLE: conv_start=1 registers all four operands and resets limb idx=0 and borrow=0; next SUB.
//  - SUB: one limb per cycle, LSB first. diff[i] = p[i] - n[i] - borrow.
//    After NL cycles the final borrow per lane is its sign, neg_x / neg_y.
//  - CHK (1 cycle): if neg_x|neg_y, go to ADD with idx=0 and carry=0; else go to DONE.
//  - ADD: NL cycles, limb-serial. A lane adds P[i] only if its neg flag is set, else adds 0.
//    The final carry out is discarded; the result lies in [0,P).
//  - DONE: load x_out/y_out, pulse conv_done=1 for one cycle, then IDLE.
//  Latency and result hold
//  - Start sampled in cycle k: conv_done rises in cycle k+NL+2 with no correction, k+2NL+2 with correction.
//  - With NL=4 that is k+6 or k+10.
//  - x_out/y_out change only in DONE and hold until the next DONE.
//  Boundary conditions
//  - conv_start while busy is ignored; no queueing.
//  - conv_start in the DONE cycle is ignored; start is accepted only in IDLE.
//  - conv_clr has priority over conv_start and the state advance.
//    Next state IDLE, conv_busy=0, no conv_done; x_out/y_out unchanged.
//  - rst has priority over conv_clr.
//  - xp==xn gives output 0 with neg=0, no ADD pass.
//  - Operand changes after the capture cycle do not affect the result.
//  - Inputs >= P are out of contract; the output is then undefined but must not hang the FSM.
// CONFIGURATION
//  EC_CONV_ZERO_FLAG_EN
//  - Defined: adds outputs x_zero and y_zero (1 bit each).
//    Each is 1 when the lane result == 0, registered in DONE alongside x_out/y_out.
//    Both are reset to 0 and held with the results; used for point-at-infinity detect.
//    Computed by ANDing per-limb zero bits accumulated in the final pass.
//  - Undefined: ports and logic are absent; latency is unchanged.
// TESTING
//  1. rst=1 for 2 cycles mid-conversion -> busy=0, done=0, x_out=y_out=0; next start converts normally.
//  2. xp=5, xn=3, yp=10, yn=10 -> done at k+6; x_out=2, y_out=0 (x_zero=0, y_zero=1 if EN).
//  3. xp=3, xn=5, yp=P-1, yn=0 -> done at k+10; x_out=P-2, y_out=P-1.
//  4. xp=0, xn=P-1 (x cross-limb borrow), y=1-0 -> x_out=1, y_out=1; done at k+10.
//  5. Start, then conv_clr at k+3 -> no done; outputs keep previous values; a new start at k+5 is accepted.
//  6. conv_start pulses at k+2..k+8 while busy -> exactly one done; results match operands captured at k.

Source files
------------

// File: rtl/ec_rdc_conv.sv
// ec_rdc_conv
//   Converts redundant EC point coordinates (xp,xn),(yp,yn) into canonical
//   binary mod P:  x = (xp - xn) mod P,  y = (yp - yn) mod P.
//   Two lanes (lane 0 = x, lane 1 = y) share one limb-serial sequencer:
//     SUB : NL cycles of limb subtract with borrow (final borrow = sign)
//     CHK : one cycle, decide whether a correction pass is needed
//     ADD : NL cycles of limb add of P (only in a negative lane) with carry
//     DONE: results visible, conv_done high for one cycle
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   conv_start           capture operands and begin (accepted only in IDLE)
//   conv_clr             abort to IDLE, results retained
//   ecp3_xp/xn/yp/yn     redundant operands, each in [0,P)
//   conv_busy            high from cycle after accepted start through DONE
//   conv_done            one-cycle pulse, x_out/y_out valid
//   x_out, y_out         canonical results in [0,P)
//   x_zero, y_zero       (EC_CONV_ZERO_FLAG_EN only) lane result == 0
//
// Optional feature macro: EC_CONV_ZERO_FLAG_EN
module ec_rdc_conv #(
    parameter int              WIDTH = 256,
    parameter int              LIMB  = 64,
    parameter logic [WIDTH-1:0] P    = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             conv_start,
    input  logic             conv_clr,
    input  logic [WIDTH-1:0] ecp3_xp,
    input  logic [WIDTH-1:0] ecp3_xn,
    input  logic [WIDTH-1:0] ecp3_yp,
    input  logic [WIDTH-1:0] ecp3_yn,
    output logic             conv_busy,
    output logic             conv_done,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out
`ifdef EC_CONV_ZERO_FLAG_EN
    ,
    output logic             x_zero,
    output logic             y_zero
`endif
);
    localparam int NL = WIDTH / LIMB;
    localparam int IW = (NL > 1) ? $clog2(NL) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SUB  = 3'd1;
    localparam logic [2:0] S_CHK  = 3'd2;
    localparam logic [2:0] S_ADD  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]            state;
    logic [IW-1:0]         idx;
    logic [1:0][WIDTH-1:0] op_p, op_n;   // captured operands, lane-indexed
    logic [1:0][WIDTH-1:0] acc;          // result shift register, limbs enter at the top
    logic [1:0]            bc;           // borrow in SUB, carry in ADD
    logic [1:0]            neg;          // lane sign after SUB

    logic [1:0][LIMB:0]    limb_s;
    logic [1:0][WIDTH-1:0] acc_nxt;
    logic [1:0]            bc_nxt;
    logic [LIMB-1:0]       p_limb;
    logic                  last;

    assign last      = (idx == IW'(NL - 1));
    assign p_limb    = P[idx*LIMB +: LIMB];
    assign conv_busy = (state != S_IDLE);
    assign conv_done = (state == S_DONE);

    // One limb step per lane. In ADD the limb consumed is the bottom of acc,
    // which after SUB holds the difference in natural order; shifting the
    // sum back in at the top restores natural order after NL steps.
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            limb_s[l] = '0;
            if (state == S_ADD)
                limb_s[l] = {1'b0, acc[l][LIMB-1:0]}
                          + {1'b0, (neg[l] ? p_limb : {LIMB{1'b0}})}
                          + (LIMB+1)'(bc[l]);
            else
                limb_s[l] = {1'b0, op_p[l][idx*LIMB +: LIMB]}
                          - {1'b0, op_n[l][idx*LIMB +: LIMB]}
                          - (LIMB+1)'(bc[l]);
            // top bit is the borrow (wrapped subtract) or the carry (add)
            bc_nxt[l]  = limb_s[l][LIMB];
            acc_nxt[l] = {limb_s[l][LIMB-1:0], acc[l][WIDTH-1:LIMB]};
        end
    end

`ifdef EC_CONV_ZERO_FLAG_EN
    // zacc ANDs per-limb zero bits over whichever pass is the final one;
    // it is re-armed when the ADD pass starts.
    logic [1:0] zacc;
    logic [1:0] limb_zero;
    always_comb begin
        for (int l = 0; l < 2; l++)
            limb_zero[l] = (limb_s[l][LIMB-1:0] == {LIMB{1'b0}});
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            op_p  <= '0;
            op_n  <= '0;
            acc   <= '0;
            bc    <= '0;
            neg   <= '0;
            x_out <= '0;
            y_out <= '0;
`ifdef EC_CONV_ZERO_FLAG_EN
            zacc   <= '0;
            x_zero <= 1'b0;
            y_zero <= 1'b0;
`endif
        end else if (conv_clr) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (conv_start) begin
                    op_p  <= {ecp3_yp, ecp3_xp};
                    op_n  <= {ecp3_yn, ecp3_xn};
                    idx   <= '0;
                    bc    <= '0;
`ifdef EC_CONV_ZERO_FLAG_EN
                    zacc  <= '1;
`endif
                    state <= S_SUB;
                end
                S_SUB: begin
                    acc <= acc_nxt;
                    bc  <= bc_nxt;
                    idx <= last ? '0 : idx + IW'(1);
`ifdef EC_CONV_ZERO_FLAG_EN
                    zacc <= zacc & limb_zero;
`endif
                    if (last) state <= S_CHK;
                end
                S_CHK: begin
                    neg <= bc;
                    if (|bc) begin
                        idx   <= '0;
                        bc    <= '0;
`ifdef EC_CONV_ZERO_FLAG_EN
                        zacc  <= '1;
`endif
                        state <= S_ADD;
                    end else begin
                        x_out <= acc[0];
                        y_out <= acc[1];
`ifdef EC_CONV_ZERO_FLAG_EN
                        x_zero <= zacc[0];
                        y_zero <= zacc[1];
`endif
                        state <= S_DONE;
                    end
                end
                S_ADD: begin
                    // final carry out is dropped: result wraps into [0,P)
                    acc <= acc_nxt;
                    bc  <= bc_nxt;
                    idx <= last ? '0 : idx + IW'(1);
`ifdef EC_CONV_ZERO_FLAG_EN
                    zacc <= zacc & limb_zero;
`endif
                    if (last) begin
                        x_out <= acc_nxt[0];
                        y_out <= acc_nxt[1];
`ifdef EC_CONV_ZERO_FLAG_EN
                        x_zero <= zacc[0] & limb_zero[0];
                        y_zero <= zacc[1] & limb_zero[1];
`endif
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ec_rdc_conv.sv
// Self-checking bench for ec_rdc_conv: directed cases plus random operands
// against a modular-subtract reference model.
module tb_ec_rdc_conv;
    localparam logic [255:0] P = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

    logic         clk = 1'b0;
    logic         rst, conv_start, conv_clr;
    logic [255:0] xp, xn, yp, yn;
    logic         conv_busy, conv_done;
    logic [255:0] x_out, y_out;
`ifdef EC_CONV_ZERO_FLAG_EN
    logic         x_zero, y_zero;
`endif

    ec_rdc_conv dut (
        .clk(clk), .rst(rst), .conv_start(conv_start), .conv_clr(conv_clr),
        .ecp3_xp(xp), .ecp3_xn(xn), .ecp3_yp(yp), .ecp3_yn(yn),
        .conv_busy(conv_busy), .conv_done(conv_done),
        .x_out(x_out), .y_out(y_out)
`ifdef EC_CONV_ZERO_FLAG_EN
        , .x_zero(x_zero), .y_zero(y_zero)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [255:0] ex_x = '0, ex_y = '0;   // results the outputs should hold

    function automatic logic [255:0] mod_sub(input logic [255:0] a, input logic [255:0] b);
        if (a >= b) return a - b;
        return a + (P - b);
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        if (v >= P) v = v - P;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_x"}, x_out, ex_x);
        chk({tag, "_y"}, y_out, ex_y);
`ifdef EC_CONV_ZERO_FLAG_EN
        chk({tag, "_xz"}, 256'(x_zero), 256'(ex_x == '0));
        chk({tag, "_yz"}, 256'(y_zero), 256'(ex_y == '0));
`endif
    endtask

    // Start one conversion, scramble the operand inputs right after capture,
    // and check latency, results and the single-cycle done pulse.
    task automatic run_conv(input string tag, input logic [255:0] a, input logic [255:0] b,
                            input logic [255:0] c, input logic [255:0] d);
        int cnt;
        bit got;
        int lat;
        @(negedge clk);
        xp = a; xn = b; yp = c; yn = d; conv_start = 1'b1;
        @(posedge clk);
        ex_x = mod_sub(a, b);
        ex_y = mod_sub(c, d);
        lat  = (a < b || c < d) ? 10 : 6;
        cnt  = 0;
        got  = 1'b0;
        while (!got && cnt < 30) begin
            @(negedge clk);
            conv_start = 1'b0;
            xp = rand256(); xn = rand256(); yp = rand256(); yn = rand256();
            cnt++;
            if (cnt == 1) chk({tag, "_busy"}, 256'(conv_busy), 256'(1));
            if (conv_done) got = 1'b1;
        end
        chk({tag, "_lat"}, 256'(cnt), 256'(lat));
        chk_outputs(tag);
        @(negedge clk);
        chk({tag, "_pulse"}, 256'({conv_done, conv_busy}), 256'(0));
    endtask

    initial begin
        int cnt;
        int ndone;
        int first_done;
        rst = 1'b1; conv_start = 1'b0; conv_clr = 1'b0;
        xp = '0; xn = '0; yp = '0; yn = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 256'(conv_busy), 256'(0));
        chk("rst_done", 256'(conv_done), 256'(0));
        chk_outputs("rst");
        rst = 1'b0;

        // basic cases
        run_conv("t2", 256'd5, 256'd3, 256'd10, 256'd10);
        run_conv("t3", 256'd3, 256'd5, P - 256'd1, 256'd0);

        // reset for two cycles mid-conversion
        @(negedge clk);
        xp = 256'd1; xn = 256'd9; yp = 256'd4; yn = 256'd2; conv_start = 1'b1;
        @(negedge clk); conv_start = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ex_x = '0; ex_y = '0;
        chk("mrst_busy", 256'(conv_busy), 256'(0));
        chk("mrst_done", 256'(conv_done), 256'(0));
        chk_outputs("mrst");

        run_conv("t4", 256'd0, P - 256'd1, 256'd1, 256'd0);

        // abort with conv_clr at k+3, restart at k+5
        @(negedge clk);
        xp = 256'd7; xn = 256'd100; yp = 256'd2; yn = 256'd1; conv_start = 1'b1;
        @(posedge clk);
        ndone = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            conv_start = 1'b0;
            conv_clr   = (c == 3);
            if (conv_done) ndone++;
        end
        conv_clr = 1'b0;
        chk("clr_done", 256'(ndone), 256'(0));
        chk("clr_busy", 256'(conv_busy), 256'(0));
        chk_outputs("clr_hold");
        run_conv("t5", 256'd20, 256'd11, 256'd6, 256'd6);

        // start pulses at k+2..k+8 while busy must be ignored
        @(negedge clk);
        xp = 256'd3; xn = 256'd5; yp = 256'd77; yn = 256'd7; conv_start = 1'b1;
        @(posedge clk);
        ex_x = mod_sub(256'd3, 256'd5);
        ex_y = 256'd70;
        ndone = 0; first_done = 0;
        for (cnt = 1; cnt <= 20; cnt++) begin
            @(negedge clk);
            conv_start = (cnt >= 2 && cnt <= 8);
            xp = rand256(); xn = rand256(); yp = rand256(); yn = rand256();
            if (conv_done) begin
                ndone++;
                if (first_done == 0) begin
                    first_done = cnt;
                    chk_outputs("t6");
                end
            end
        end
        conv_start = 1'b0;
        chk("t6_ndone", 256'(ndone), 256'(1));
        chk("t6_lat", 256'(first_done), 256'(10));

        // random operands, with occasional equal pairs
        for (int i = 0; i < 16; i++) begin
            logic [255:0] a, b, c, d;
            a = rand256(); b = rand256(); c = rand256(); d = rand256();
            if (i % 5 == 0) b = a;
            if (i % 7 == 3) d = c;
            run_conv("rnd", a, b, c, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
